// File: rtl/dec_onehot_seq_if.sv
// Bus bundle for dec_onehot_seq: control, select load port and strobe outputs.
// master = the block driving select/control, slave = the decoder itself.
interface dec_onehot_seq_if #(
    parameter int SEL_W   = 2,
    parameter int OUTS    = 4,
    parameter int DWELL_W = 8
);
    logic               en;
    logic               mode;
    logic               din_valid;
    logic [SEL_W-1:0]   din;
    logic               din_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUTS-1:0]    dout;
    logic [SEL_W-1:0]   dout_idx;
    logic               wrap;
    logic               err;

    modport master (
        output en, mode, din_valid, din, dwell,
        input  din_ready, dout, dout_idx, wrap, err
    );

    modport slave (
        input  en, mode, din_valid, din, dwell,
        output din_ready, dout, dout_idx, wrap, err
    );
endinterface

// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: registered binary-to-one-hot decoder with a valid/ready
// load port (direct mode) and a self-timed line scanner (scan mode).
// Optional macro DEC_HOLD_EN: when defined, dout/dout_idx hold their last
// value while the block is disabled; by default they clear to zero.
module dec_onehot_seq #(
    parameter int SEL_W   = 2,
    parameter int OUTS    = 4,
    parameter int DWELL_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    dec_onehot_seq_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIRECT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam logic [OUTS-1:0]  ONE  = OUTS'(1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(OUTS - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [OUTS-1:0]    dout_r;
    logic [SEL_W-1:0]   idx_r;
    logic [DWELL_W-1:0] cnt;
    logic               wrap_r;
    logic               err_r;
    logic               in_range;

    // Extra MSB so OUTS == 2**SEL_W still compares correctly.
    assign in_range = ({1'b0, bus.din} < (SEL_W + 1)'(OUTS));

    // Next state follows en/mode directly; it also selects this edge's action.
    always_comb begin
        state_nxt = IDLE;
        if (bus.en) state_nxt = bus.mode ? SCAN : DIRECT;
    end

    // Loads are only accepted in direct mode, so ready mirrors that condition.
    assign bus.din_ready = bus.en & ~bus.mode;

    // Main state, strobe, dwell counter and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            dout_r <= '0;
            idx_r  <= '0;
            cnt    <= '0;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_nxt)
                DIRECT: begin
                    cnt <= '0;
                    // state_nxt == DIRECT implies din_ready, so valid alone is a transfer
                    if (bus.din_valid) begin
                        idx_r <= bus.din;
                        if (in_range) begin
                            dout_r <= ONE << bus.din;
                        end else begin
                            dout_r <= '0;
                            err_r  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (state != SCAN) begin
                        // fresh entry always restarts at line 0 without a wrap pulse
                        dout_r <= ONE;
                        idx_r  <= '0;
                        cnt    <= '0;
                    end else if (cnt >= bus.dwell) begin
                        // dwell is compared live, so lowering it ends the line early
                        cnt <= '0;
                        if (idx_r == LAST) begin
                            dout_r <= ONE;
                            idx_r  <= '0;
                            wrap_r <= 1'b1;
                        end else begin
                            dout_r <= dout_r << 1;
                            idx_r  <= idx_r + SEL_W'(1);
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    cnt <= '0;
`ifdef DEC_HOLD_EN
                    // legacy enable-decoder behaviour: strobe holds while disabled
`else
                    dout_r <= '0;
                    idx_r  <= '0;
`endif
                end
            endcase
        end
    end

    assign bus.dout     = dout_r;
    assign bus.dout_idx = idx_r;
    assign bus.wrap     = wrap_r;
    assign bus.err      = err_r;
endmodule
